// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command layer: header decode, register access, capture FIFO streaming
// Optional underflow counter (cmd 0x05) is built in when SPI_CMD_UFCNT_EN is defined.
module spi_cmd_ctrl #(
    parameter logic [7:0] CTRL_RST   = 8'h00,
    parameter logic [7:0] FILTER_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_rx,
    input  logic       eob,
    input  logic       busy,
    input  logic       spi_err,
    output logic [7:0] data_tx,
    output logic       err_out,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic [7:0] cfg_ctrl,
    output logic [7:0] cfg_filter
);

    localparam logic [4:0] CMD_CTRL   = 5'h01;
    localparam logic [4:0] CMD_FILTER = 5'h02;
    localparam logic [4:0] CMD_STATUS = 5'h03;
    localparam logic [4:0] CMD_STREAM = 5'h04;
    localparam logic [4:0] CMD_UFCNT  = 5'h05;

    typedef enum logic [1:0] {IDLE, HDR, EXEC, ERR} state_t;

    state_t     state, state_next;
    logic       eob_q, busy_q;
    logic       eob_p, busy_rise, busy_fall;
    logic       hdr_read;
    logic [4:0] hdr_cmd;
    logic       wr_done, status_frame;
    logic       under_sticky, err_sticky;
    logic [7:0] tx_next, reg_val;
    logic       rd_next, wr_ctrl, wr_filter, set_under, latch_hdr, act;
    logic       cur_read;
    logic [4:0] cur_cmd;
`ifdef SPI_CMD_UFCNT_EN
    logic [7:0] ufcnt;
`endif

    assign eob_p     = eob & ~eob_q;
    assign busy_rise = busy & ~busy_q;
    assign busy_fall = ~busy & busy_q;

    // Read-only commands reject the write direction.
    function automatic logic cmd_ok(input logic [4:0] cmd, input logic rd);
        case (cmd)
            CMD_CTRL, CMD_FILTER:   cmd_ok = 1'b1;
            CMD_STATUS, CMD_STREAM: cmd_ok = rd;
`ifdef SPI_CMD_UFCNT_EN
            CMD_UFCNT:              cmd_ok = rd;
`endif
            default:                cmd_ok = 1'b0;
        endcase
    endfunction

    always_comb begin
        reg_val = 8'h00;
        case (cur_cmd)
            CMD_CTRL:   reg_val = cfg_ctrl;
            CMD_FILTER: reg_val = cfg_filter;
            CMD_STATUS: reg_val = {fifo_empty, under_sticky, err_sticky, 5'b0};
`ifdef SPI_CMD_UFCNT_EN
            CMD_UFCNT:  reg_val = ufcnt;
`endif
            default:    reg_val = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        tx_next    = data_tx;
        rd_next    = 1'b0;
        wr_ctrl    = 1'b0;
        wr_filter  = 1'b0;
        set_under  = 1'b0;
        latch_hdr  = 1'b0;
        act        = 1'b0;
        // In HDR the header is still on data_rx; afterwards it comes from the latch.
        cur_read   = (state == HDR) ? data_rx[6]   : hdr_read;
        cur_cmd    = (state == HDR) ? data_rx[4:0] : hdr_cmd;
        case (state)
            IDLE: begin
                tx_next = 8'h00;
                if (busy_rise) state_next = HDR;
            end
            HDR: begin
                if (eob_p) begin
                    latch_hdr = 1'b1;
                    if (cmd_ok(data_rx[4:0], data_rx[6])) begin
                        state_next = EXEC;
                        act        = 1'b1;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            EXEC:    act = eob_p;
            default: ;
        endcase
        if (act) begin
            if (!cur_read) begin
                tx_next = 8'h00;
                if (state == EXEC && !wr_done) begin
                    wr_ctrl   = (cur_cmd == CMD_CTRL);
                    wr_filter = (cur_cmd == CMD_FILTER);
                end
            end else if (cur_cmd == CMD_STREAM) begin
                if (!fifo_empty) begin
                    rd_next = 1'b1;
                    tx_next = fifo_data;
                end else begin
                    tx_next   = 8'h00;
                    set_under = 1'b1;
                end
            end else begin
                tx_next = reg_val;
            end
        end
        if (state != IDLE && spi_err) state_next = ERR;
        if (!busy) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eob_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_tx      <= 8'h00;
            fifo_rd      <= 1'b0;
            err_out      <= 1'b0;
            hdr_read     <= 1'b0;
            hdr_cmd      <= 5'h00;
            wr_done      <= 1'b0;
            status_frame <= 1'b0;
            under_sticky <= 1'b0;
            err_sticky   <= 1'b0;
            cfg_ctrl     <= CTRL_RST;
            cfg_filter   <= FILTER_RST;
`ifdef SPI_CMD_UFCNT_EN
            ufcnt        <= 8'h00;
`endif
        end else begin
            state   <= state_next;
            eob_q   <= eob;
            busy_q  <= busy;
            data_tx <= tx_next;
            fifo_rd <= rd_next;
            err_out <= (state == ERR) && busy;
            if (latch_hdr) begin
                hdr_read     <= data_rx[6];
                hdr_cmd      <= data_rx[4:0];
                wr_done      <= 1'b0;
                status_frame <= data_rx[6] && (data_rx[4:0] == CMD_STATUS);
            end
            if (wr_ctrl) begin
                cfg_ctrl <= data_rx;
                wr_done  <= 1'b1;
            end
            if (wr_filter) begin
                cfg_filter <= data_rx;
                wr_done    <= 1'b1;
            end
            if (busy_fall) status_frame <= 1'b0;
            // Reading STATUS acknowledges the stickies once the frame closes.
            if (busy_fall && status_frame) begin
                under_sticky <= 1'b0;
                err_sticky   <= 1'b0;
`ifdef SPI_CMD_UFCNT_EN
                ufcnt        <= 8'h00;
`endif
            end else begin
                if (set_under) under_sticky <= 1'b1;
                if (state == ERR) err_sticky <= 1'b1;
`ifdef SPI_CMD_UFCNT_EN
                if (set_under && ufcnt != 8'hFF) ufcnt <= ufcnt + 8'h01;
`endif
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed scoreboard bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_rx;
    logic       eob, busy, spi_err;
    logic [7:0] data_tx;
    logic       err_out;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] cfg_ctrl, cfg_filter;

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    int rd_base;
    logic [7:0] sb[$];

    logic [7:0] mem [0:15];
    logic [4:0] wr_ptr = 5'd0;
    logic [4:0] rd_ptr = 5'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_count <= rd_count + 1;
            if (wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 5'd1;
        end
    end

    spi_cmd_ctrl #(.CTRL_RST(8'h3C), .FILTER_RST(8'hC3)) dut (
        .clk(clk), .rst(rst), .data_rx(data_rx), .eob(eob), .busy(busy),
        .spi_err(spi_err), .data_tx(data_tx), .err_out(err_out),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .cfg_ctrl(cfg_ctrl), .cfg_filter(cfg_filter)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_fifo(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic start_frame();
        @(negedge clk);
        busy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        busy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Expected data_tx is pushed with the byte and popped one clock after eob rises.
    task automatic send_byte(input logic [7:0] b, input int hold, input logic chk, input logic [7:0] exp);
        if (chk) sb.push_back(exp);
        @(negedge clk);
        data_rx = b;
        eob = 1'b1;
        @(negedge clk);
        if (sb.size() > 0) check("data_tx", data_tx, sb.pop_front());
        repeat (hold - 1) @(negedge clk);
        eob = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; data_rx = 8'h00; eob = 1'b0; busy = 1'b0; spi_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_tx", data_tx, 8'h00);
        check("rst_err_out", {7'b0, err_out}, 8'h00);
        check("rst_fifo_rd", {7'b0, fifo_rd}, 8'h00);
        check("rst_cfg_ctrl", cfg_ctrl, 8'h3C);
        check("rst_cfg_filter", cfg_filter, 8'hC3);

        start_frame();
        send_byte(8'h01, 1, 1'b1, 8'h00);
        send_byte(8'hA5, 1, 1'b1, 8'h00);
        check("wr_ctrl", cfg_ctrl, 8'hA5);
        send_byte(8'h5A, 1, 1'b0, 8'h00);
        end_frame();
        check("wr_ctrl_first_only", cfg_ctrl, 8'hA5);

        start_frame();
        send_byte(8'h41, 1, 1'b1, 8'hA5);
        send_byte(8'h00, 1, 1'b1, 8'hA5);
        end_frame();
        check("idle_data_tx", data_tx, 8'h00);

        start_frame();
        send_byte(8'h02, 1, 1'b0, 8'h00);
        send_byte(8'h77, 1, 1'b0, 8'h00);
        end_frame();
        start_frame();
        send_byte(8'h42, 1, 1'b1, 8'h77);
        end_frame();

        push_fifo(8'h11);
        push_fifo(8'h22);
        rd_base = rd_count;
        start_frame();
        send_byte(8'h44, 1, 1'b1, 8'h11);
        send_byte(8'h00, 1, 1'b1, 8'h22);
        send_byte(8'h00, 1, 1'b1, 8'h00);
        send_byte(8'h00, 1, 1'b1, 8'h00);
        end_frame();
        check("stream_pops", 8'(rd_count - rd_base), 8'd2);

        start_frame();
        send_byte(8'h43, 1, 1'b1, 8'hC0);
        end_frame();
        start_frame();
        send_byte(8'h43, 1, 1'b1, 8'h80);
        end_frame();

        start_frame();
        send_byte(8'h03, 1, 1'b0, 8'h00);
        check("err_out_set", {7'b0, err_out}, 8'h01);
        send_byte(8'h99, 1, 1'b0, 8'h00);
        check("err_out_hold", {7'b0, err_out}, 8'h01);
        check("err_ctrl_kept", cfg_ctrl, 8'hA5);
        check("err_filter_kept", cfg_filter, 8'h77);
        end_frame();
        check("err_out_drop", {7'b0, err_out}, 8'h00);
        start_frame();
        send_byte(8'h43, 1, 1'b1, 8'hA0);
        end_frame();
        start_frame();
        send_byte(8'h43, 1, 1'b1, 8'h80);
        end_frame();

        push_fifo(8'h33);
        rd_base = rd_count;
        start_frame();
        send_byte(8'h44, 3, 1'b1, 8'h33);
        check("long_eob_pop", 8'(rd_count - rd_base), 8'd1);
        send_byte(8'h00, 3, 1'b1, 8'h00);
        end_frame();
        check("long_eob_no_pop_empty", 8'(rd_count - rd_base), 8'd1);
        start_frame();
        send_byte(8'h43, 1, 1'b1, 8'hC0);
        end_frame();

        start_frame();
        send_byte(8'h01, 1, 1'b0, 8'h00);
        @(negedge clk);
        data_rx = 8'h66; eob = 1'b1; busy = 1'b0;
        @(negedge clk);
        check("wr_at_busy_fall", cfg_ctrl, 8'h66);
        eob = 1'b0;
        repeat (3) @(negedge clk);

`ifdef SPI_CMD_UFCNT_EN
        start_frame();
        send_byte(8'h44, 1, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1, 1'b1, 8'h00);
        end_frame();
        start_frame();
        send_byte(8'h45, 1, 1'b1, 8'h05);
        check("ufcnt_no_err", {7'b0, err_out}, 8'h00);
        end_frame();
`else
        start_frame();
        send_byte(8'h45, 1, 1'b0, 8'h00);
        check("ufcnt_absent_err", {7'b0, err_out}, 8'h01);
        end_frame();
`endif

        start_frame();
        send_byte(8'h41, 1, 1'b1, 8'h66);
        @(negedge clk);
        spi_err = 1'b1;
        @(negedge clk);
        spi_err = 1'b0;
        @(negedge clk);
        check("spi_err_to_err", {7'b0, err_out}, 8'h01);
        end_frame();

        push_fifo(8'h44);
        push_fifo(8'h55);
        start_frame();
        send_byte(8'h44, 1, 1'b1, 8'h44);
        @(negedge clk);
        data_rx = 8'h00; eob = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_fifo_rd", {7'b0, fifo_rd}, 8'h00);
        check("rst_mid_data_tx", data_tx, 8'h00);
        check("rst_mid_cfg_ctrl", cfg_ctrl, 8'h3C);
        eob = 1'b0; busy = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
